// File: rtl/bpb_pkg.sv
// Shared types and defaults for the branch predictor: counter encoding and
// the default entry count / tag width.
package bpb_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bpb_ctr_t;

    localparam int unsigned BPB_E = 16;
    localparam int unsigned BPB_T = 8;

endpackage

// File: rtl/sat_ctr2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_ctr2
    import bpb_pkg::*;
(
    input  bpb_ctr_t i_ctr,
    input  logic     i_taken,
    output bpb_ctr_t o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        case (i_ctr)
            CTR_SNT: o_ctr = i_taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: o_ctr = i_taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  o_ctr = i_taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  o_ctr = i_taken ? CTR_ST  : CTR_WT;
            default: o_ctr = i_ctr;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup at
// fetch, update from decode, plus saturating branch/mispredict counters.
module branch_target_buffer
    import bpb_pkg::*;
#(
    parameter int unsigned ENTRIES   = BPB_E,
    parameter int unsigned TAG_WIDTH = BPB_T
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic        stall,
    input  logic        flush,
    input  logic        isbranch,
    input  logic        real_taken,
    input  logic [31:0] real_adr,
    output logic        predict_taken,
    output logic [31:0] predict_adr,
    output logic        mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    logic                 r_valid  [ENTRIES];
    logic [TAG_WIDTH-1:0] r_tag    [ENTRIES];
    bpb_ctr_t             r_ctr    [ENTRIES];
    logic [31:0]          r_target [ENTRIES];

    logic [IDX-1:0]       r_idx_d;
    logic [TAG_WIDTH-1:0] r_tag_d;
    logic                 r_hit_d;
    bpb_ctr_t             r_ctr_d;
    logic                 r_pred_taken_d;
    logic [31:0]          r_pred_target_d;

    logic [31:0]          r_branch_cnt;
    logic [31:0]          r_mispred_cnt;

    logic [IDX-1:0]       w_idx_f;
    logic [TAG_WIDTH-1:0] w_tag_f;
    logic                 w_hit_f;
    logic                 w_pred_taken_f;
    logic                 w_update;
    logic                 w_mispredict;
    bpb_ctr_t             w_ctr_next;

    assign w_idx_f        = pc_f[IDX+1:2];
    assign w_tag_f        = pc_f[TAG_WIDTH+IDX+1:IDX+2];
    assign w_hit_f        = r_valid[w_idx_f] & (r_tag[w_idx_f] == w_tag_f);
    assign w_pred_taken_f = w_hit_f & r_ctr[w_idx_f][1];

    assign predict_taken = w_pred_taken_f;
    assign predict_adr   = r_target[w_idx_f];

    assign w_update     = isbranch & ~stall;
    assign w_mispredict = isbranch &
                          ((r_pred_taken_d != real_taken) |
                           (real_taken & r_pred_taken_d & (r_pred_target_d != real_adr)));
    assign mispredict   = w_mispredict;

    // Counter step uses the state captured at lookup, so the update matches
    // what the prediction was based on.
    sat_ctr2 u_sat_ctr2 (
        .i_ctr   (r_ctr_d),
        .i_taken (real_taken),
        .o_ctr   (w_ctr_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx_d         <= '0;
            r_tag_d         <= '0;
            r_hit_d         <= 1'b0;
            r_ctr_d         <= CTR_SNT;
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (flush) begin
            r_idx_d         <= '0;
            r_tag_d         <= '0;
            r_hit_d         <= 1'b0;
            r_ctr_d         <= CTR_SNT;
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
        end else if (!stall) begin
            r_idx_d         <= w_idx_f;
            r_tag_d         <= w_tag_f;
            r_hit_d         <= w_hit_f;
            r_ctr_d         <= r_ctr[w_idx_f];
            r_pred_taken_d  <= w_pred_taken_f;
            r_pred_target_d <= r_target[w_idx_f];
        end
    end

    // Targets are cleared too so predict_adr is deterministic out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= CTR_SNT;
                r_target[i] <= '0;
            end
        end else if (w_update) begin
            if (r_hit_d) begin
                r_ctr[r_idx_d] <= w_ctr_next;
                if (real_taken) begin
                    r_target[r_idx_d] <= real_adr;
                end
            end else if (real_taken) begin
                r_valid[r_idx_d]  <= 1'b1;
                r_tag[r_idx_d]    <= r_tag_d;
                r_ctr[r_idx_d]    <= CTR_WT;
                r_target[r_idx_d] <= real_adr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_update) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vector table,
// stall/flush/bypass sequences and randomized traffic against a model.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        stall;
    logic        flush;
    logic        isbranch;
    logic        real_taken;
    logic [31:0] real_adr;
    logic        predict_taken;
    logic [31:0] predict_adr;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_target_buffer #(.ENTRIES(16), .TAG_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_f          (pc_f),
        .stall         (stall),
        .flush         (flush),
        .isbranch      (isbranch),
        .real_taken    (real_taken),
        .real_adr      (real_adr),
        .predict_taken (predict_taken),
        .predict_adr   (predict_adr),
        .mispredict    (mispredict),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one entry per index, direction strength 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int          m_str   [16];
    logic [31:0] m_tgt   [16];
    int unsigned e_br  = 0;
    int unsigned e_mis = 0;

    function automatic int unsigned m_idx(input logic [31:0] pc);
        return (pc >> 2) % 16;
    endfunction

    function automatic int unsigned m_tg(input logic [31:0] pc);
        return (pc >> 6) % 256;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_str[m_idx(pc)] >= 2);
    endfunction

    function automatic void m_update(input logic [31:0] pc, input bit taken,
                                     input logic [31:0] adr, input bit hit);
        int unsigned i;
        i = m_idx(pc);
        if (hit) begin
            if (taken) begin
                m_str[i] = (m_str[i] == 3) ? 3 : m_str[i] + 1;
                m_tgt[i] = adr;
            end else begin
                m_str[i] = (m_str[i] == 0) ? 0 : m_str[i] - 1;
            end
        end else if (taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = m_tg(pc);
            m_str[i]   = 2;
            m_tgt[i]   = adr;
        end
    endfunction

    task automatic chk_cnts(input string name);
        chk({name, "_brcnt"}, branch_cnt, e_br);
        chk({name, "_miscnt"}, mispred_cnt, e_mis);
    endtask

    // One branch: lookup cycle, then resolve in D the following cycle.
    task automatic xact(input logic [31:0] pc, input bit taken, input logic [31:0] adr,
                        input bit exp_pt, input logic [31:0] exp_pa, input bit exp_mis,
                        input string name);
        bit hit;
        hit = m_hit(pc);
        @(negedge clk);
        pc_f = pc; isbranch = 1'b0; stall = 1'b0; flush = 1'b0;
        #2;
        chk({name, "_pt"}, {31'd0, predict_taken}, {31'd0, exp_pt});
        if (exp_pt) chk({name, "_pa"}, predict_adr, exp_pa);
        @(negedge clk);
        isbranch = 1'b1; real_taken = taken; real_adr = adr; pc_f = pc + 32'd4;
        #2;
        chk({name, "_mis"}, {31'd0, mispredict}, {31'd0, exp_mis});
        @(posedge clk);
        #1;
        isbranch = 1'b0;
        e_br++;
        if (exp_mis) e_mis++;
        m_update(pc, taken, adr, hit);
        chk_cnts(name);
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          taken;
        logic [31:0] adr;
        bit          pt;
        logic [31:0] pa;
        bit          mis;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] rpc;
        logic [31:0] radr;
        bit          rtk;
        bit          ept;
        bit          emis;

        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_str[i] = 0; m_tgt[i] = '0;
        end

        //            pc          tk adr         pt pa          mis
        tbl[0]  = '{32'h040, 1'b1, 32'h100, 1'b0, 32'h000, 1'b1};
        tbl[1]  = '{32'h040, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0};
        tbl[2]  = '{32'h040, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0};
        tbl[3]  = '{32'h040, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0};
        tbl[4]  = '{32'h040, 1'b0, 32'h000, 1'b1, 32'h100, 1'b1};
        tbl[5]  = '{32'h040, 1'b0, 32'h000, 1'b1, 32'h100, 1'b1};
        tbl[6]  = '{32'h040, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0};
        tbl[7]  = '{32'h040, 1'b1, 32'h100, 1'b0, 32'h000, 1'b1};
        tbl[8]  = '{32'h040, 1'b1, 32'h180, 1'b0, 32'h000, 1'b1};
        tbl[9]  = '{32'h040, 1'b1, 32'h100, 1'b1, 32'h180, 1'b1};
        tbl[10] = '{32'h440, 1'b1, 32'h200, 1'b0, 32'h000, 1'b1};
        tbl[11] = '{32'h040, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0};
        tbl[12] = '{32'h440, 1'b0, 32'h000, 1'b1, 32'h200, 1'b1};

        // Reset held for three cycles.
        reset = 1'b0; pc_f = 32'h40; stall = 1'b0; flush = 1'b0;
        isbranch = 1'b0; real_taken = 1'b0; real_adr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #2;
        chk("rst_pt", {31'd0, predict_taken}, 32'd0);
        chk("rst_mis", {31'd0, mispredict}, 32'd0);
        chk_cnts("rst");

        for (int i = 0; i < 13; i++) begin
            xact(tbl[i].pc, tbl[i].taken, tbl[i].adr, tbl[i].pt, tbl[i].pa, tbl[i].mis,
                 $sformatf("vec%0d", i));
        end

        // Branch held in D by stall for four cycles updates once.
        @(negedge clk);
        pc_f = 32'h84; isbranch = 1'b0;
        #2 chk("stl_pt", {31'd0, predict_taken}, 32'd0);
        @(negedge clk);
        isbranch = 1'b1; real_taken = 1'b1; real_adr = 32'h300; stall = 1'b1; pc_f = 32'h0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("stl_mis%0d", k), {31'd0, mispredict}, 32'd1);
            chk($sformatf("stl_br%0d", k), branch_cnt, e_br);
            @(negedge clk);
        end
        stall = 1'b0;
        #2 chk("stl_mis_go", {31'd0, mispredict}, 32'd1);
        @(posedge clk);
        #1 isbranch = 1'b0;
        e_br++; e_mis++;
        m_update(32'h84, 1'b1, 32'h300, 1'b0);
        chk_cnts("stl");
        @(negedge clk);
        pc_f = 32'h84;
        #2;
        chk("stl_after_pt", {31'd0, predict_taken}, 32'd1);
        chk("stl_after_pa", predict_adr, 32'h300);

        // Flush after a hit clears the D register: a resolved taken branch
        // then mispredicts and allocates at index 0 with tag 0.
        @(negedge clk);
        pc_f = 32'h84; flush = 1'b1;
        #2 chk("fl_pt", {31'd0, predict_taken}, 32'd1);
        @(negedge clk);
        flush = 1'b0; isbranch = 1'b1; real_taken = 1'b1; real_adr = 32'h300; pc_f = 32'h8;
        #2 chk("fl_mis", {31'd0, mispredict}, 32'd1);
        @(posedge clk);
        #1 isbranch = 1'b0;
        e_br++; e_mis++;
        m_update(32'h0, 1'b1, 32'h300, 1'b0);
        chk_cnts("fl");
        @(negedge clk);
        pc_f = 32'h0;
        #2;
        chk("fl_alloc_pt", {31'd0, predict_taken}, 32'd1);
        chk("fl_alloc_pa", predict_adr, 32'h300);

        // Update still happens when isbranch coincides with flush.
        @(negedge clk);
        pc_f = 32'h84;
        @(negedge clk);
        isbranch = 1'b1; real_taken = 1'b0; flush = 1'b1; pc_f = 32'h8;
        #2 chk("flb_mis", {31'd0, mispredict}, 32'd1);
        @(posedge clk);
        #1 isbranch = 1'b0; flush = 1'b0;
        e_br++; e_mis++;
        m_update(32'h84, 1'b0, 32'h0, 1'b1);
        chk_cnts("flb");
        @(negedge clk);
        pc_f = 32'h84;
        #2 chk("flb_pt", {31'd0, predict_taken}, 32'd0);

        // Same-index lookup during the update sees the old entry.
        @(negedge clk);
        pc_f = 32'h0;
        #2 chk("rw_pt0", {31'd0, predict_taken}, 32'd1);
        @(negedge clk);
        isbranch = 1'b1; real_taken = 1'b1; real_adr = 32'h380; pc_f = 32'h0;
        #2;
        chk("rw_mis", {31'd0, mispredict}, 32'd1);
        chk("rw_old_pa", predict_adr, 32'h300);
        @(posedge clk);
        #1 isbranch = 1'b0;
        e_br++; e_mis++;
        m_update(32'h0, 1'b1, 32'h380, 1'b1);
        chk_cnts("rw");
        #2;
        chk("rw_new_pt", {31'd0, predict_taken}, 32'd1);
        chk("rw_new_pa", predict_adr, 32'h380);

        // Randomized traffic over a few indices/tags against the model.
        for (int n = 0; n < 200; n++) begin
            rpc  = (32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 3)) << 6) |
                   (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            rtk  = 1'($urandom_range(0, 1));
            radr = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h40;
            ept  = m_pred(rpc);
            emis = (ept != rtk) || (rtk && ept && (m_tgt[m_idx(rpc)] != radr));
            xact(rpc, rtk, radr, ept, m_tgt[m_idx(rpc)], emis, $sformatf("rnd%0d", n));
        end

        // Reset asserted during an update cycle wins.
        @(negedge clk);
        pc_f = 32'h1C4; isbranch = 1'b0;
        @(negedge clk);
        isbranch = 1'b1; real_taken = 1'b1; real_adr = 32'h500;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        e_br = 0; e_mis = 0;
        chk_cnts("mid_rst");
        @(negedge clk);
        reset = 1'b1; isbranch = 1'b0;
        #2 chk("mid_rst_pt", {31'd0, predict_taken}, 32'd0);
        chk_cnts("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters for the 5-stage MIPS pipeline. It is looked up combinationally with the fetch PC and returns a predicted-taken flag and target for the next-PC mux. It is updated from the decode stage once the branch outcome (`pcsrcD`) and target (`pcbranchD`) resolve. It also keeps branch and mispredict performance counters.

## Interface

**Parameters**
- `ENTRIES`, default 16: number of entries; must be a power of two, ≥ 2. `IDX = $clog2(ENTRIES)`.
- `TAG_WIDTH`, default 8: tag bits stored per entry. Requires `TAG_WIDTH + IDX + 2 ≤ 32`.

**Ports**
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pc_f` in 32: fetch-stage PC.
- `stall` in 1: decode stall (`stallD`); holds the F→D prediction register.
- `flush` in 1: decode flush (`flushD`); clears the F→D prediction register.
- `isbranch` in 1: the instruction in D is beq/bne.
- `real_taken` in 1: resolved direction in D.
- `real_adr` in 32: resolved branch target in D.
- `predict_taken` out 1: fetch-stage prediction.
- `predict_adr` out 32: fetch-stage predicted target.
- `mispredict` out 1: the D-stage branch was mispredicted (combinational).
- `branch_cnt` out 32: count of branches resolved.
- `mispred_cnt` out 32: count of mispredicts.

## Operation

**Address split**
- Index = `pc[IDX+1:2]`.
- Tag = `pc[TAG_WIDTH+IDX+1:IDX+2]`.

**Entry contents**
- `valid`, `tag`, `ctr[1:0]`, `target[31:0]`.
- Counter states: 00 = strong-not-taken, 01 = weak-not-taken, 10 = weak-taken, 11 = strong-taken.

**Lookup (F, combinational)**
- `hitF = valid[idx] & (tag[idx] == tagF)`.
- `predict_taken = hitF & ctr[idx][1]`.
- `predict_adr = target[idx]`. When `predict_taken` is 0, the value is don't-care but must be deterministic.

**F→D register**
- Fields: `{idx, tag, hit, ctr, pred_taken, pred_target}`.
- `reset` → all fields 0.
- `flush` → all fields 0; flush has priority over stall.
- `stall` → hold.
- Otherwise load from F.

**Update (D, clocked)**
- An update occurs when `isbranch & ~stall`. It uses the registered idx and tag, not `pc_f`.
- Hit:
  - `ctr` saturates up if `real_taken`, down otherwise: 11 stays at 11, 00 stays at 00.
  - If `real_taken`, `target <= real_adr`.
- Miss and `real_taken`: allocate, overwriting any prior occupant. Set `valid = 1`, `tag = tagD`, `ctr = 10`, `target = real_adr`.
- Miss and not taken: no write.

**Mispredict**
- `mispredict = isbranch & (pred_takenD != real_taken | (real_taken & pred_takenD & pred_targetD != real_adr))`.

**Performance counters**
- Both count only when `isbranch & ~stall`.
- `branch_cnt` increments on every such branch.
- `mispred_cnt` increments when `mispredict` is also set.
- Both saturate at `32'hFFFF_FFFF`; they do not wrap.

**Reset**
- Clears all `valid` bits and all counters, and sets the performance counters to 0.
- Resulting output values: `predict_taken = 0`, `mispredict = 0`, `branch_cnt = 0`, `mispred_cnt = 0`.
- An asserted reset mid-update wins; no write occurs.

## Timing

- Lookup has zero latency: `predict_*` follows `pc_f` in the same cycle.
- An update is written at the rising edge ending the D cycle and is visible to lookups from the next cycle.
- Same-index lookup and update in the same cycle: the lookup returns the old contents. There is no write-to-read bypass.
- A branch held in D by `stall` updates exactly once, in the first cycle with `stall = 0`.
- `isbranch` while `flush` is high: the update still occurs. Flush affects only the instruction entering D.

## Structure

- A shared package `bpb_pkg` holds:
  - the typedef `bpb_ctr_t` (2-bit), with constants `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`;
  - `BPB_E` and `BPB_T` defaults, mirroring `bpb.vh`.
- One sub-module, `sat_ctr2`, computes the next state of the 2-bit saturating counter (combinational).
- The storage arrays are flops; no RAM macro.

## Test plan

All scenarios use `ENTRIES=16`, `TAG_WIDTH=8`.

1. **Reset:** release `reset` after 3 cycles with `pc_f=0x40` → `predict_taken=0`, `branch_cnt=0`, `mispred_cnt=0`.
2. **Cold taken branch:** `pc_f=0x40`, next cycle `isbranch=1`, `real_taken=1`, `real_adr=0x100` → `mispredict=1`, `mispred_cnt=1`. A later lookup of `0x40` gives `predict_taken=1`, `predict_adr=0x100`.
3. **Saturation:** the same branch taken 3 more times → `ctr=11`. Then not-taken once → still predicted taken (`ctr=10`). Not-taken again → `predict_taken=0`.
4. **Aliasing:** after scenario 2, look up `pc_f=0x440` (same index, tag 0x11 ≠ 0x01) → `predict_taken=0`. Resolve it taken to `0x200` → the entry is replaced and `0x40` now misses.
5. **Stall/flush:** a branch in D with `stall=1` for 4 cycles → `branch_cnt` increments once. A lookup hit followed by `flush` → the D register is cleared and no update occurs with `isbranch=0`.
6. **Same-cycle read/write:** update idx 0 while `pc_f` maps to idx 0 → the prediction in that cycle reflects the old entry; the next cycle reflects the new one.
